reel_engine: RTL and testbench
==============================

REEL_ENGINE -- requirements
Module: reel_engine

Interface
REQ-001 The module SHALL have parameter NUM_REELS, default 3: number of independent reels.
REQ-002 The module SHALL have parameter SYMS_PER_REEL, default 4: symbols per reel strip, range 2..16.
REQ-003 The module SHALL have parameter SYM_H, default 120: symbol height in pixels, range 16..255.
REQ-004 The module SHALL have parameter SPEED_MAX, default 8: peak speed in pixels/frame, range 1..SYM_H.
REQ-005 The module SHALL have parameter STOP_GAP, default 20: frames between successive reel stop enables.
REQ-006 The module SHALL have port CLK, input, 1 bit: the single clock.
REQ-007 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port frame_tick, input, 1 bit: one-CLK pulse per video frame.
REQ-009 The module SHALL have port spin_start, input, 1 bit: one-CLK request to start all reels.
REQ-010 The module SHALL have port stop_req, input, 1 bit: one-CLK request to begin staggered stopping.
REQ-011 The module SHALL have port sym_idx, output, NUM_REELS*4 bits: per-reel top symbol index, reel k at [4k+3:4k].
REQ-012 The module SHALL have port phase, output, NUM_REELS*8 bits: per-reel pixel phase within the top symbol, 0..SYM_H-1.
REQ-013 The module SHALL have port reel_moving, output, NUM_REELS bits: 1 while reel k is not IDLE.
REQ-014 The module SHALL have port busy, output, 1 bit: OR of reel_moving.
REQ-015 The module SHALL have port done, output, 1 bit: one-CLK pulse when the last moving reel stops.

Function
REQ-016 Each reel SHALL run an FSM with states IDLE, ACCEL, SPIN, DECEL, and SHALL update only on CLK cycles where frame_tick=1.
REQ-017 spin_start while busy=0 SHALL move every reel to ACCEL with speed 1 on the next CLK; spin_start while busy=1 SHALL be ignored.
REQ-018 On each frame_tick, a non-IDLE reel SHALL advance: phase+speed; if the sum is >=SYM_H, phase SHALL become sum-SYM_H and sym_idx SHALL become (sym_idx+1) mod SYMS_PER_REEL.
REQ-019 ACCEL: speed SHALL increment by 1 per frame_tick after the advance; when speed reaches SPEED_MAX the reel SHALL enter SPIN.
REQ-020 stop_req SHALL be accepted only when all reels are in SPIN; otherwise it SHALL be ignored, with no pending latch.
REQ-021 After stop_req is accepted, reel k SHALL receive its stop enable on the (k*STOP_GAP)-th subsequent frame_tick, so reel 0 stops on the first tick.
REQ-022 A stop enable SHALL move the reel from SPIN to DECEL on that tick; the advance at the current speed still occurs on that tick.
REQ-023 DECEL: after each advance, speed SHALL decrement by 1, floored at 1.
REQ-024 DECEL: if speed is 1 and the post-advance phase is 0, the reel SHALL enter IDLE with speed 0.
REQ-025 While IDLE, phase SHALL be 0, so the stopped sym_idx is the reel result.
REQ-026 done SHALL pulse for exactly one CLK on the cycle after busy falls 1->0.
REQ-027 If spin_start and frame_tick coincide, the reel SHALL start only; the first advance SHALL occur on the next frame_tick.
REQ-028 If stop_req and frame_tick coincide, the stop SHALL be accepted, and that same tick SHALL count as stagger tick 0.
REQ-029 Outputs SHALL be registered, with one-CLK latency from the frame_tick edge.

Reset
REQ-030 reset SHALL, on the CLK edge where it is high, override all other inputs and set phase=0, speed=0, state=IDLE, and sym_idx[k]=k mod SYMS_PER_REEL.
REQ-031 reset SHALL clear reel_moving, busy, done, and the stagger counter.
REQ-032 reset asserted mid-spin SHALL abort the spin without generating a done pulse.

Structure
REQ-033 Package reel_pkg SHALL hold the reel_state_t enum (IDLE, ACCEL, SPIN, DECEL) and the field widths 4 (sym_idx) and 8 (phase/speed).
REQ-034 Per-reel logic SHALL be a sub-module reel_channel, instantiated NUM_REELS times by a generate loop.
REQ-035 The stagger counter and the done logic SHALL reside in reel_engine.

Verification
REQ-036 The bench SHALL check: reset -> sym_idx = {2,1,0} (reels 2..0), phase = 0, busy = 0, done = 0.
REQ-037 The bench SHALL check: spin_start, then 8 frame_ticks -> all reels in SPIN, speed 8, and phase = 1+2+...+8 = 36.
REQ-038 The bench SHALL check: spin_start pulsed while busy -> no state change.
REQ-039 The bench SHALL check: stop_req during ACCEL -> ignored, and reels keep spinning.
REQ-040 The bench SHALL check: stop_req in SPIN -> reel 0 idles first, reels 1 and 2 follow at least 20 and 40 frames later, each with phase = 0, and done pulses once, one CLK after the last stop.
REQ-041 The bench SHALL check: reset asserted during DECEL -> immediate IDLE, sym_idx back to initial values, and no done pulse.

Source files
------------

// File: rtl/reel_pkg.sv
// Shared types and field widths for the slot-machine reel engine.
//   reel_state_t : per-reel motion state
//   SYM_W / PH_W : widths of the symbol index and of phase/speed
package reel_pkg;

   localparam int unsigned SYM_W = 4;
   localparam int unsigned PH_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCEL = 2'd1,
      SPIN  = 2'd2,
      DECEL = 2'd3
   } reel_state_t;

endpackage

// File: rtl/reel_channel.sv
// One reel: position (symbol index + pixel phase), speed and motion FSM.
// The reel moves only on frame ticks.
//   CLK, reset   : clock, synchronous active-high reset
//   frame_tick   : one pulse per video frame
//   start        : accepted spin request (reel must be IDLE)
//   stop_en      : stop enable, valid together with frame_tick
//   sym_idx      : top symbol index
//   phase        : pixel phase within the top symbol
//   state        : current FSM state
//   moving       : reel is not IDLE
module reel_channel
   import reel_pkg::*;
#(
   parameter int unsigned SYMS_PER_REEL = 4,
   parameter int unsigned SYM_H         = 120,
   parameter int unsigned SPEED_MAX     = 8,
   parameter int unsigned INIT_SYM      = 0
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic             start,
   input  logic             stop_en,
   output logic [SYM_W-1:0] sym_idx,
   output logic [PH_W-1:0]  phase,
   output reel_state_t      state,
   output logic             moving
);

   localparam logic [PH_W:0]    SYM_H_X  = (PH_W+1)'(SYM_H);
   localparam logic [PH_W-1:0]  SPD_MAX  = PH_W'(SPEED_MAX);
   localparam logic [PH_W-1:0]  SPD_ONE  = PH_W'(1);
   localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMS_PER_REEL - 1);

   reel_state_t      r_state, w_state_nxt;
   logic [PH_W-1:0]  r_speed, r_phase;
   logic [PH_W-1:0]  w_speed_nxt, w_phase_nxt, w_ph_adv, w_spd_inc;
   logic [SYM_W-1:0] r_sym, w_sym_nxt, w_sym_adv;
   logic [PH_W:0]    w_sum;
   logic             w_wrap, w_land;

   // Advance by one frame: the sum never exceeds 2*SYM_H, so one subtraction wraps it
   assign w_sum     = {1'b0, r_phase} + {1'b0, r_speed};
   assign w_wrap    = (w_sum >= SYM_H_X);
   assign w_ph_adv  = w_wrap ? PH_W'(w_sum - SYM_H_X) : w_sum[PH_W-1:0];
   assign w_sym_adv = !w_wrap ? r_sym :
                      (r_sym == SYM_LAST) ? '0 : r_sym + SYM_W'(1);
   assign w_spd_inc = (r_speed >= SPD_MAX) ? r_speed : r_speed + SPD_ONE;
   // Crawling at speed 1 and landing exactly on a symbol boundary
   assign w_land    = (r_speed == SPD_ONE) && (w_ph_adv == '0);

   // State register
   always_ff @(posedge CLK) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic; a start on a tick cycle only starts the reel
   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = ACCEL;
      end else if (frame_tick) begin
         case (r_state)
            ACCEL:   if (w_spd_inc >= SPD_MAX) w_state_nxt = SPIN;
            SPIN:    if (stop_en)              w_state_nxt = DECEL;
            DECEL:   if (w_land)               w_state_nxt = IDLE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // Output/datapath logic: position and speed follow the state
   always_comb begin
      w_speed_nxt = r_speed;
      w_phase_nxt = r_phase;
      w_sym_nxt   = r_sym;
      if (start) begin
         w_speed_nxt = SPD_ONE;
      end else if (frame_tick && (r_state != IDLE)) begin
         w_phase_nxt = w_ph_adv;
         w_sym_nxt   = w_sym_adv;
         case (r_state)
            ACCEL:   w_speed_nxt = w_spd_inc;
            DECEL:   if (w_land)                w_speed_nxt = '0;
                     else if (r_speed > SPD_ONE) w_speed_nxt = r_speed - SPD_ONE;
            default: w_speed_nxt = r_speed;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_speed <= '0;
         r_phase <= '0;
         r_sym   <= SYM_W'(INIT_SYM);
      end else begin
         r_speed <= w_speed_nxt;
         r_phase <= w_phase_nxt;
         r_sym   <= w_sym_nxt;
      end
   end

   assign sym_idx = r_sym;
   assign phase   = r_phase;
   assign state   = r_state;
   assign moving  = (r_state != IDLE);

endmodule

// File: rtl/reel_engine.sv
// Multi-reel slot engine: starts all reels together, stops them one by one
// STOP_GAP frames apart and flags completion.
//   CLK, reset   : clock, synchronous active-high reset
//   frame_tick   : one pulse per video frame
//   spin_start   : start all reels (ignored while busy)
//   stop_req     : begin staggered stop (only when every reel is in SPIN)
//   sym_idx      : reel k top symbol at [4k+3:4k]
//   phase        : reel k pixel phase at [8k+7:8k]
//   reel_moving  : reel k not IDLE
//   busy         : any reel moving
//   done         : one-cycle pulse, the cycle after busy falls
module reel_engine
   import reel_pkg::*;
#(
   parameter int unsigned NUM_REELS     = 3,
   parameter int unsigned SYMS_PER_REEL = 4,
   parameter int unsigned SYM_H         = 120,
   parameter int unsigned SPEED_MAX     = 8,
   parameter int unsigned STOP_GAP      = 20
) (
   input  logic                       CLK,
   input  logic                       reset,
   input  logic                       frame_tick,
   input  logic                       spin_start,
   input  logic                       stop_req,
   output logic [NUM_REELS*SYM_W-1:0] sym_idx,
   output logic [NUM_REELS*PH_W-1:0]  phase,
   output logic [NUM_REELS-1:0]       reel_moving,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned     LAST_TICK = (NUM_REELS - 1) * STOP_GAP;
   localparam int unsigned     CNT_W     = $clog2(LAST_TICK + 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_TICK);

   reel_state_t          w_state [NUM_REELS];
   logic [NUM_REELS-1:0] w_stop_en;
   logic                 w_start, w_all_spin, w_stop_accept, w_stag_active, w_stag_tick;
   logic [CNT_W-1:0]     r_cnt, w_tick_num;
   logic                 r_stopping, r_busy_q, r_done;

   assign busy    = |reel_moving;
   assign w_start = spin_start && !busy;

   always_comb begin
      w_all_spin = 1'b1;
      for (int i = 0; i < int'(NUM_REELS); i++)
         if (w_state[i] != SPIN) w_all_spin = 1'b0;
   end

   // A stop accepted on a tick cycle makes that tick stagger tick 0
   assign w_stop_accept = stop_req && w_all_spin && !r_stopping;
   assign w_stag_active = w_stop_accept || r_stopping;
   assign w_tick_num    = w_stop_accept ? '0 : r_cnt;
   assign w_stag_tick   = frame_tick && w_stag_active;

   // Stagger counter: counts frame ticks since the stop was accepted
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_stopping <= 1'b0;
         r_cnt      <= '0;
      end else if (w_stag_tick) begin
         if (w_tick_num == CNT_LAST) begin
            r_stopping <= 1'b0;
            r_cnt      <= '0;
         end else begin
            r_stopping <= 1'b1;
            r_cnt      <= w_tick_num + CNT_W'(1);
         end
      end else if (w_stop_accept) begin
         r_stopping <= 1'b1;
         r_cnt      <= '0;
      end
   end

   // Completion pulse, one cycle after busy falls; reset leaves no history
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_busy_q <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_busy_q <= busy;
         r_done   <= r_busy_q && !busy;
      end
   end

   assign done = r_done;

   for (genvar k = 0; k < int'(NUM_REELS); k++) begin : g_reel
      localparam logic [CNT_W-1:0] STOP_AT = CNT_W'(k * STOP_GAP);

      assign w_stop_en[k] = w_stag_tick && (w_tick_num == STOP_AT);

      reel_channel #(
         .SYMS_PER_REEL (SYMS_PER_REEL),
         .SYM_H         (SYM_H),
         .SPEED_MAX     (SPEED_MAX),
         .INIT_SYM      (k % SYMS_PER_REEL)
      ) u_reel (
         .CLK        (CLK),
         .reset      (reset),
         .frame_tick (frame_tick),
         .start      (w_start),
         .stop_en    (w_stop_en[k]),
         .sym_idx    (sym_idx[k*SYM_W +: SYM_W]),
         .phase      (phase[k*PH_W +: PH_W]),
         .state      (w_state[k]),
         .moving     (reel_moving[k])
      );
   end

endmodule

// File: tb/tb_reel_engine.sv
// Scoreboard bench for reel_engine: a position-based reference model predicts
// every cycle's outputs; a monitor pops and compares after each clock edge.
module tb_reel_engine;

   localparam int N    = 3;
   localparam int SYMS = 4;
   localparam int H    = 120;
   localparam int SMAX = 8;
   localparam int GAP  = 20;
   localparam int L    = SYMS * H;

   localparam int M_IDLE = 0, M_ACCEL = 1, M_SPIN = 2, M_DECEL = 3;

   logic          CLK = 1'b0;
   logic          reset = 1'b0, frame_tick = 1'b0, spin_start = 1'b0, stop_req = 1'b0;
   logic [11:0]   sym_idx;
   logic [23:0]   phase;
   logic [2:0]    reel_moving;
   logic          busy, done;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;

   // reference model state: absolute pixel position along the strip
   int  m_pos [N];
   int  m_spd [N];
   int  m_mode[N];
   int  m_ticks, m_base;
   bit  m_active, m_bo, m_bq;
   logic [63:0] m_exp;
   logic [63:0] exp_q [$];
   logic [63:0] mon_exp;

   reel_engine #(
      .NUM_REELS(N), .SYMS_PER_REEL(SYMS), .SYM_H(H), .SPEED_MAX(SMAX), .STOP_GAP(GAP)
   ) dut (
      .CLK(CLK), .reset(reset), .frame_tick(frame_tick), .spin_start(spin_start),
      .stop_req(stop_req), .sym_idx(sym_idx), .phase(phase), .reel_moving(reel_moving),
      .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit ft, input bit ss, input bit sr);
      bit busy_pre, all_spin, en, busy_new, done_e;
      logic [11:0] sv;
      logic [23:0] pv;
      logic [2:0]  mv;
      done_e = 1'b0;
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            m_pos[k] = (k % SYMS) * H; m_spd[k] = 0; m_mode[k] = M_IDLE;
         end
         m_active = 1'b0; m_ticks = 0; m_base = 0; m_bo = 1'b0; m_bq = 1'b0;
      end else begin
         busy_pre = 1'b0; all_spin = 1'b1;
         for (int k = 0; k < N; k++) begin
            if (m_mode[k] != M_IDLE) busy_pre = 1'b1;
            if (m_mode[k] != M_SPIN) all_spin = 1'b0;
         end
         done_e = m_bq && !m_bo;
         if (sr && all_spin) begin m_base = m_ticks; m_active = 1'b1; end
         if (ss && !busy_pre) begin
            for (int k = 0; k < N; k++) begin m_mode[k] = M_ACCEL; m_spd[k] = 1; end
         end else if (ft) begin
            for (int k = 0; k < N; k++) begin
               en = m_active && (m_ticks == m_base + k * GAP);
               if (m_mode[k] != M_IDLE) m_pos[k] = (m_pos[k] + m_spd[k]) % L;
               case (m_mode[k])
                  M_ACCEL: begin
                     if (m_spd[k] < SMAX) m_spd[k]++;
                     if (m_spd[k] >= SMAX) m_mode[k] = M_SPIN;
                  end
                  M_SPIN: if (en) m_mode[k] = M_DECEL;
                  M_DECEL: begin
                     if (m_spd[k] == 1 && m_pos[k] % H == 0) begin
                        m_mode[k] = M_IDLE; m_spd[k] = 0;
                     end else if (m_spd[k] > 1) m_spd[k]--;
                  end
                  default: ;
               endcase
            end
            if (m_active && m_ticks == m_base + (N - 1) * GAP) m_active = 1'b0;
            m_ticks++;
         end
      end
      busy_new = 1'b0;
      for (int k = 0; k < N; k++) begin
         sv[k*4 +: 4] = 4'(m_pos[k] / H);
         pv[k*8 +: 8] = 8'(m_pos[k] % H);
         mv[k]        = (m_mode[k] != M_IDLE);
         if (mv[k]) busy_new = 1'b1;
      end
      if (!rst) begin m_bq = m_bo; m_bo = busy_new; end
      m_exp = {23'b0, sv, pv, mv, busy_new, done_e};
   endtask

   // drive one clock cycle of inputs (called at a falling edge)
   task automatic cycle(input bit rst, input bit ft, input bit ss, input bit sr);
      reset = rst; frame_tick = ft; spin_start = ss; stop_req = sr;
      model_step(rst, ft, ss, sr);
      exp_q.push_back(m_exp);
      @(negedge CLK);
   endtask

   task automatic tick();
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 0);
   endtask

   // monitor: compare every registered output set against the model
   always @(posedge CLK) begin
      #1;
      if (done === 1'b1) n_done++;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         chk("scoreboard", {23'b0, sym_idx, phase, reel_moving, busy, done}, mon_exp);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int fall[N];
      logic [2:0] prev_mv;
      int t;

      @(negedge CLK);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      chk("reset_sym",   64'(sym_idx), 64'h210);
      chk("reset_phase", 64'(phase),   64'h0);
      chk("reset_busy",  64'(busy),    64'h0);
      chk("reset_done",  64'(done),    64'h0);

      // start coinciding with a tick: start only, no advance
      cycle(0, 1, 1, 0);
      chk("start_phase",  64'(phase),       64'h0);
      chk("start_moving", 64'(reel_moving), 64'h7);
      repeat (3) tick();
      chk("accel3_phase", 64'(phase), 64'h060606);
      cycle(0, 0, 0, 1);               // stop during ACCEL: ignored
      cycle(0, 0, 1, 0);               // start while busy: ignored
      chk("busy_start_phase", 64'(phase),   64'h060606);
      chk("busy_start_sym",   64'(sym_idx), 64'h210);
      repeat (5) tick();
      chk("spin8_phase", 64'(phase), 64'h242424);
      chk("spin8_busy",  64'(busy),  64'h1);
      tick();
      chk("spin_speed8_phase", 64'(phase), 64'h2c2c2c);

      // staggered stop, accepted on a tick
      n_done = 0;
      fall = '{-1, -1, -1};
      cycle(0, 1, 0, 1);
      prev_mv = reel_moving;
      t = 1;
      while (busy === 1'b1 && t < 600) begin
         cycle(0, 0, 0, 0);
         cycle(0, 1, 0, 0);
         for (int k = 0; k < N; k++)
            if (prev_mv[k] && !reel_moving[k]) fall[k] = t;
         prev_mv = reel_moving;
         t++;
      end
      chk("stop_busy_falls", 64'(busy), 64'h0);
      repeat (3) cycle(0, 0, 0, 0);
      chk("stop_phase0",   64'(phase), 64'h0);
      chk("stop_done_once", 64'(n_done), 64'd1);
      chk("reel0_first",   64'(fall[0] >= 0 && fall[0] < fall[1] && fall[0] < fall[2]), 64'h1);
      chk("reel1_gap20",   64'(fall[1] - fall[0] >= 20), 64'h1);
      chk("reel2_gap40",   64'(fall[2] - fall[0] >= 40), 64'h1);

      // reset during DECEL aborts without done
      cycle(0, 0, 1, 0);
      repeat (9) tick();
      cycle(0, 1, 0, 1);
      tick();
      tick();
      chk("decel_moving", 64'(reel_moving), 64'h7);
      n_done = 0;
      cycle(1, 0, 0, 0);
      chk("abort_sym",   64'(sym_idx),     64'h210);
      chk("abort_phase", 64'(phase),       64'h0);
      chk("abort_busy",  64'(busy),        64'h0);
      chk("abort_mov",   64'(reel_moving), 64'h0);
      repeat (4) cycle(0, 0, 0, 0);
      chk("abort_no_done", 64'(n_done), 64'd0);

      // randomized traffic against the model
      for (int i = 0; i < 20000; i++)
         cycle(($urandom % 5000) == 0, ($urandom % 3) == 0,
               ($urandom % 40) == 0, ($urandom % 25) == 0);
      cycle(0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
